// File: rtl/rng_pkg.sv
// Shared constants, update-source encoding and the xorshift32 next-state
// function for the xorshift random number generator.
package rng_pkg;

  // Default reset state; any nonzero value works, zero is the lock-up point.
  localparam logic [31:0] RNG_DEFAULT_SEED = 32'h2545_F491;

  // Marsaglia xorshift32 shift triple.
  localparam int RNG_SHIFT_A = 13;
  localparam int RNG_SHIFT_B = 17;
  localparam int RNG_SHIFT_C = 5;

  // Width of the CR16-facing half word and of the range bound.
  localparam int RNG_HALF_W = 16;

  // Which source updates the state register on the coming edge.
  typedef enum logic [1:0] {
    UPD_HOLD  = 2'd0,
    UPD_STEP  = 2'd1,
    UPD_LOAD  = 2'd2,
    UPD_RESET = 2'd3
  } upd_sel_e;

  // One xorshift32 step; shifted-out bits drop, vacated bits fill with zero.
  function automatic logic [31:0] xorshift32_next(
    input logic [31:0] x,
    input int          sa = RNG_SHIFT_A,
    input int          sb = RNG_SHIFT_B,
    input int          sc = RNG_SHIFT_C
  );
    logic [31:0] t1;
    logic [31:0] t2;
    // NOTE: blocking assignments are correct here: t1 and t2 are
    // intermediate combinational values read later in the same evaluation.
    t1 = x ^ (x << sa);
    t2 = t1 ^ (t1 >> sb);
    return t2 ^ (t2 << sc);
  endfunction

  // A loaded seed of zero would freeze the generator, so it maps to the seed.
  function automatic logic [31:0] safe_seed(
    input logic [31:0] requested,
    input logic [31:0] fallback
  );
    return (requested == 32'd0) ? fallback : requested;
  endfunction

endpackage : rng_pkg

// File: rtl/xorshift_step.sv
// Purely combinational 32-bit xorshift next-state function, kept separate so
// it can be exercised on its own.
module xorshift_step
  import rng_pkg::*;
#(
  parameter int SHIFT_A = RNG_SHIFT_A,
  parameter int SHIFT_B = RNG_SHIFT_B,
  parameter int SHIFT_C = RNG_SHIFT_C
) (
  input  logic [31:0] i_state,
  output logic [31:0] o_next
);

  // Next state derived from the current state with the configured shifts.
  always_comb begin
    o_next = xorshift32_next(i_state, SHIFT_A, SHIFT_B, SHIFT_C);
  end

endmodule : xorshift_step

// File: rtl/xor_shift_rng.sv
// Free-running xorshift32 generator with seed load, a 16-bit view for direct
// CR16 register loads, and a range-bounded value in [0, range_in).
module xor_shift_rng
  import rng_pkg::*;
#(
  parameter logic [31:0] SEED    = RNG_DEFAULT_SEED,
  parameter int          SHIFT_A = RNG_SHIFT_A,
  parameter int          SHIFT_B = RNG_SHIFT_B,
  parameter int          SHIFT_C = RNG_SHIFT_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] seed_in,
  input  logic [15:0] range_in,
  output logic [31:0] rand_out,
  output logic [15:0] rand16,
  output logic [15:0] rand_bounded,
  output logic        valid
);

  logic [31:0] r_state;
  logic        r_valid;
  logic [31:0] w_next;
  logic [31:0] w_load_value;
  logic [31:0] w_product;
  upd_sel_e    w_sel;

  xorshift_step #(
    .SHIFT_A (SHIFT_A),
    .SHIFT_B (SHIFT_B),
    .SHIFT_C (SHIFT_C)
  ) u_step (
    .i_state (r_state),
    .o_next  (w_next)
  );

  assign w_load_value = safe_seed(seed_in, SEED);

  // Resolve the per-edge priority: reset, then load, then en, else hold.
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred when none of the branches below fire.
    w_sel = UPD_HOLD;
    if (reset) begin
      w_sel = UPD_RESET;
    end else if (load) begin
      w_sel = UPD_LOAD;
    end else if (en) begin
      w_sel = UPD_STEP;
    end
  end

  // State register and advance pulse; valid marks only en-driven advances.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before the edge, independent of statement order.
    unique case (w_sel)
      UPD_RESET: begin
        r_state <= SEED;
        r_valid <= 1'b0;
      end
      UPD_LOAD: begin
        r_state <= w_load_value;
        r_valid <= 1'b0;
      end
      UPD_STEP: begin
        r_state <= w_next;
        r_valid <= 1'b1;
      end
      default: begin
        r_valid <= 1'b0;
      end
    endcase
  end

  // Scale the low half word into [0, range_in): upper half of the product.
  always_comb begin
    w_product    = {16'd0, r_state[RNG_HALF_W-1:0]} * {16'd0, range_in};
    rand_bounded = 16'(w_product >> RNG_HALF_W);
  end

  assign rand_out = r_state;
  assign rand16   = r_state[RNG_HALF_W-1:0];
  assign valid    = r_valid;

endmodule : xor_shift_rng

// File: tb/tb_xor_shift_rng.sv
// Self-checking bench for xor_shift_rng: directed cases followed by random
// control traffic compared against a behavioural model.
module tb_xor_shift_rng;

  localparam logic [31:0] SEED = 32'h2545_F491;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [31:0] seed_in = 32'd0;
  logic [15:0] range_in = 16'd0;
  logic [31:0] rand_out;
  logic [15:0] rand16;
  logic [15:0] rand_bounded;
  logic        valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of what the outputs should be.
  logic [31:0] m_state;
  logic        m_valid;

  xor_shift_rng dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .load         (load),
    .seed_in      (seed_in),
    .range_in     (range_in),
    .rand_out     (rand_out),
    .rand16       (rand16),
    .rand_bounded (rand_bounded),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // xorshift32 via plain arithmetic: multiply for left shift, divide for right.
  function automatic logic [31:0] ref_next(input logic [31:0] x);
    longint unsigned a, b, c;
    a = (longint'(x) ^ ((longint'(x) * 64'd8192) % 64'h1_0000_0000));
    b = a ^ (a / 64'd131072);
    c = b ^ ((b * 64'd32) % 64'h1_0000_0000);
    return c[31:0];
  endfunction

  function automatic logic [15:0] ref_bound(input logic [31:0] st, input logic [15:0] r);
    longint unsigned p;
    p = longint'(st % 32'd65536) * longint'(r);
    return 16'(p / 64'd65536);
  endfunction

  // Drive one cycle of controls, advance the model, sample 1 time unit later.
  task automatic cyc(input logic r, input logic l, input logic e, input logic [31:0] s);
    reset = r; load = l; en = e; seed_in = s;
    @(posedge clk);
    #1;
    if (r) begin
      m_state = SEED; m_valid = 1'b0;
    end else if (l) begin
      m_state = (s == 32'd0) ? SEED : s; m_valid = 1'b0;
    end else if (e) begin
      m_state = ref_next(m_state); m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rand_out"}, rand_out, m_state);
    check({tag, ".rand16"}, {16'd0, rand16}, {16'd0, m_state[15:0]});
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, m_valid});
    check({tag, ".bounded"}, {16'd0, rand_bounded}, {16'd0, ref_bound(m_state, range_in)});
    check({tag, ".nonzero"}, {31'd0, (rand_out == 32'd0)}, 32'd0);
  endtask

  initial begin
    m_state = SEED;
    m_valid = 1'b0;

    // Reset state.
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check("reset_state", rand_out, SEED);
    check("reset_rand16", {16'd0, rand16}, {16'd0, SEED[15:0]});
    check("reset_valid", {31'd0, valid}, 32'd0);

    // Load 1 with en low.
    cyc(1'b0, 1'b1, 1'b0, 32'd1);
    check("load_one", rand_out, 32'd1);
    check("load_one_valid", {31'd0, valid}, 32'd0);

    // Two steps from 1.
    cyc(1'b0, 1'b0, 1'b1, 32'd0);
    check("step1", rand_out, 32'h0004_2021);
    check("step1_valid", {31'd0, valid}, 32'd1);
    range_in = 16'd640;
    #1;
    check("bound_640", {16'd0, rand_bounded}, 32'd80);
    range_in = 16'd0;
    #1;
    check("bound_0", {16'd0, rand_bounded}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'd0);
    check("step2", rand_out, 32'h0408_0601);
    check("step2_valid", {31'd0, valid}, 32'd1);

    // Zero seed maps to SEED.
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    check("load_zero", rand_out, SEED);

    // Load beats en.
    cyc(1'b0, 1'b1, 1'b1, 32'h1234_5678);
    check("load_en", rand_out, 32'h1234_5678);
    check("load_en_valid", {31'd0, valid}, 32'd0);

    // Hold for five cycles, then resume without skipping a value.
    range_in = 16'd1000;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'd0);
      check_all("hold");
    end
    cyc(1'b0, 1'b0, 1'b1, 32'd0);
    check("resume", rand_out, ref_next(32'h1234_5678));
    check_all("resume");

    // Reset mid-stream, also against simultaneous load and en.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check("mid_reset", rand_out, SEED);
    check("mid_reset_valid", {31'd0, valid}, 32'd0);

    // Random control traffic with a fixed screen bound.
    range_in = 16'd480;
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom));
      check_all("rand480");
      check("lt480", {31'd0, (rand_bounded < 16'd480)}, 32'd1);
    end

    // Random bounds, including the extremes.
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0:       range_in = 16'd0;
        1:       range_in = 16'hFFFF;
        default: range_in = 16'($urandom);
      endcase
      cyc(1'b0, ($urandom_range(0, 49) == 0), 1'b1, 32'($urandom));
      check_all("randrange");
      if (range_in != 16'd0)
        check("lt_range", {31'd0, (rand_bounded < range_in)}, 32'd1);
    end

    // Long free-running stretch: state never zero.
    range_in = 16'd320;
    for (int i = 0; i < 20000; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 32'd0);
      check_all("free");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_xor_shift_rng
